// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared widths and host sequencer states for the SAD engine and its memory host
package sad_pkg;

  localparam int A_WIDTH  = 15;
  localparam int D_WIDTH  = 8;
  localparam int Ac_WIDTH = 7;
  localparam int S_WIDTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_A    = 3'd1,
    ST_LOAD_B    = 3'd2,
    ST_GO        = 3'd3,
    ST_RUN       = 3'd4,
    ST_DRAIN_RD  = 3'd5,
    ST_DRAIN_OUT = 3'd6
  } host_state_e;

endpackage

// File: rtl/sad_sp_ram.sv
// rtl/sad_sp_ram.sv - single-port synchronous RAM, read-first, one-cycle registered read
module sad_sp_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [1<<AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // read data only moves on a read strobe, otherwise it holds the last word
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem_q[addr];
  end

  // array contents are never reset so a reset keeps previously loaded data
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= wdata;
  end

  // registered read port, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sad_mem_host.sv
// rtl/sad_mem_host.sv - image/result memories and job sequencer sitting between host stream and SAD engine
module sad_mem_host #(
  parameter int A_WIDTH  = sad_pkg::A_WIDTH,
  parameter int D_WIDTH  = sad_pkg::D_WIDTH,
  parameter int Ac_WIDTH = sad_pkg::Ac_WIDTH,
  parameter int S_WIDTH  = sad_pkg::S_WIDTH
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic [D_WIDTH-1:0]  In_Data,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [S_WIDTH-1:0]  Out_Data,
  output logic                Busy,
  output logic                Go,
  input  logic [A_WIDTH-1:0]  A_Addr,
  input  logic [A_WIDTH-1:0]  B_Addr,
  input  logic                I_En,
  input  logic                I_RW,
  output logic [D_WIDTH-1:0]  A_Data,
  output logic [D_WIDTH-1:0]  B_Data,
  input  logic [Ac_WIDTH-1:0] C_Addr,
  input  logic                O_En,
  input  logic                O_RW,
  input  logic [S_WIDTH-1:0]  SAD_Out,
  input  logic                Done
);

  import sad_pkg::*;

  localparam logic [A_WIDTH-1:0]  LD_LAST  = '1;
  localparam logic [Ac_WIDTH-1:0] RD_LAST  = '1;
  localparam logic [Ac_WIDTH:0]   WR_TOTAL = {1'b1, {Ac_WIDTH{1'b0}}};

  host_state_e         state_q, state_d;
  logic [A_WIDTH-1:0]  ld_cnt_q, ld_cnt_d;
  logic [Ac_WIDTH:0]   wr_cnt_q, wr_cnt_d;
  logic [Ac_WIDTH-1:0] rd_idx_q, rd_idx_d;

  logic                in_fire;
  logic                eng_rd;
  logic                a_we, b_we, c_we, c_rd_en;
  logic [A_WIDTH-1:0]  a_addr, b_addr;
  logic [Ac_WIDTH-1:0] c_addr;

  // Done is sticky in the engine, so completion is tracked by counting writes instead
  logic done_unused;
  assign done_unused = Done;

  // host-visible status decoded straight from the state register
  always_comb begin
    In_Ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    Out_Valid = (state_q == ST_DRAIN_OUT);
    Go        = (state_q == ST_GO);
    Busy      = (state_q != ST_IDLE);
  end

  // next-state, counters and memory strobes; writes are suppressed while reset is asserted
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    wr_cnt_d = wr_cnt_q;
    rd_idx_d = rd_idx_q;
    a_we     = 1'b0;
    b_we     = 1'b0;
    c_rd_en  = 1'b0;
    eng_rd   = I_En && !I_RW;
    in_fire  = Rst && In_Valid && In_Ready;
    c_we     = Rst && (state_q == ST_RUN) && O_En && O_RW;
    if (c_we) wr_cnt_d = wr_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d  = ST_LOAD_A;
          ld_cnt_d = '0;
          wr_cnt_d = '0;
          rd_idx_d = '0;
        end
      end
      ST_LOAD_A: begin
        if (in_fire) begin
          a_we     = 1'b1;
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LD_LAST) state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (in_fire) begin
          b_we     = 1'b1;
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LD_LAST) state_d = ST_GO;
        end
      end
      ST_GO: state_d = ST_RUN;
      ST_RUN: begin
        if (wr_cnt_q == WR_TOTAL) begin
          state_d  = ST_DRAIN_RD;
          rd_idx_d = '0;
        end
      end
      ST_DRAIN_RD: begin
        c_rd_en = 1'b1;
        state_d = ST_DRAIN_OUT;
      end
      ST_DRAIN_OUT: begin
        if (Out_Ready) begin
          if (rd_idx_q == RD_LAST) begin
            state_d = ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            state_d  = ST_DRAIN_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // host and engine paths never overlap in time, so the write side simply takes the address when active
  always_comb begin
    a_addr = a_we ? ld_cnt_q : A_Addr;
    b_addr = b_we ? ld_cnt_q : B_Addr;
    c_addr = c_we ? C_Addr : rd_idx_q;
  end

  // state and counter registers
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      ld_cnt_q <= '0;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  sad_sp_ram #(.AW(A_WIDTH), .DW(D_WIDTH)) u_mem_a (
    .clk   (Clk),
    .rst_n (Rst),
    .rd_en (eng_rd),
    .wr_en (a_we),
    .addr  (a_addr),
    .wdata (In_Data),
    .rdata (A_Data)
  );

  sad_sp_ram #(.AW(A_WIDTH), .DW(D_WIDTH)) u_mem_b (
    .clk   (Clk),
    .rst_n (Rst),
    .rd_en (eng_rd),
    .wr_en (b_we),
    .addr  (b_addr),
    .wdata (In_Data),
    .rdata (B_Data)
  );

  sad_sp_ram #(.AW(Ac_WIDTH), .DW(S_WIDTH)) u_mem_c (
    .clk   (Clk),
    .rst_n (Rst),
    .rd_en (c_rd_en),
    .wr_en (c_we),
    .addr  (c_addr),
    .wdata (SAD_Out),
    .rdata (Out_Data)
  );

endmodule
